// File: rtl/data_ram_resp.sv
// data_ram_resp: far end of the MEM-stage data-RAM port.
// Latches a request, waits LAT cycles, then reads or byte-writes the internal
// word RAM. stall_o holds the pipeline until the DONE cycle, where read data
// (or an address-error pulse) is presented.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access in flight; a new request is latched here
// WAIT   | counting down wait states; access performed when cnt hits 0
// DONE   | access complete, stall released, pipeline advances
module data_ram_resp #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LAT        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en_i,
    input  logic        mem_write_en_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_select_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] ram_data_o,
    output logic        stall_o,
    output logic        addr_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [31:2]           addr_q;
    logic [3:0]            sel_q;
    logic [31:0]           data_q;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  do_access;
    logic                  addr_lanes_unused;

    logic [31:0] mem [2**DEPTH_LOG2];

    // Byte-lane bits of the address only matter to the MEM stage's lane extraction.
    assign addr_lanes_unused = ^mem_addr_i[1:0];

    assign idx       = addr_q[DEPTH_LOG2+1:2];
    assign in_range  = (addr_q[31:DEPTH_LOG2+2] == '0);
    assign do_access = !rst && (state == S_WAIT) && ram_en_i && (cnt == 4'd0);
    assign stall_o   = ram_en_i && (state != S_DONE) && !rst;

    // Sequencing FSM, wait-state counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            ram_data_o <= 32'd0;
            addr_err_o <= 1'b0;
        end else begin
            addr_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ram_en_i) begin
                        state <= S_WAIT;
                        cnt   <= LAT_CNT;
                    end
                end
                S_WAIT: begin
                    if (!ram_en_i) begin
                        // Pipeline flushed the request: abandon without side effects.
                        state <= S_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                        if (!in_range) begin
                            addr_err_o <= 1'b1;
                            if (!we_q) ram_data_o <= 32'd0;
                        end else if (!we_q) begin
                            ram_data_o <= mem[idx];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the request on acceptance so later input wiggles cannot affect the access.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && ram_en_i) begin
            we_q   <= mem_write_en_i;
            addr_q <= mem_addr_i[31:2];
            sel_q  <= mem_select_i;
            data_q <= store_data_i;
        end
    end

    // Byte-lane write into the word RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_access && we_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: two instances (LAT=2 and LAT=0) driven by a
// transaction-level model that predicts stall/data/error every cycle.
module tb_data_ram_resp;

    localparam int DL = 12;

    int lat [2] = '{2, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        en    [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  sel   [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        err   [2];

    logic [31:0] exp_data  [2];
    logic        exp_stall [2];
    logic        exp_err   [2];
    logic [31:0] mem_m [2][16];
    bit          chk_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int run [2] = '{0, 0};
    int last_run [2] = '{0, 0};

    data_ram_resp #(.DEPTH_LOG2(DL), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst[0]), .ram_en_i(en[0]), .mem_write_en_i(we[0]),
        .mem_addr_i(addr[0]), .mem_select_i(sel[0]), .store_data_i(wd[0]),
        .ram_data_o(rdata[0]), .stall_o(stall[0]), .addr_err_o(err[0])
    );

    data_ram_resp #(.DEPTH_LOG2(DL), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst[1]), .ram_en_i(en[1]), .mem_write_en_i(we[1]),
        .mem_addr_i(addr[1]), .mem_select_i(sel[1]), .store_data_i(wd[1]),
        .ram_data_o(rdata[1]), .stall_o(stall[1]), .addr_err_o(err[1])
    );

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (stall[c] !== exp_stall[c]) begin
                    errors++;
                    $display("FAIL stall ch%0d got %b want %b t=%0t", c, stall[c], exp_stall[c], $time);
                end
                checks++;
                if (rdata[c] !== exp_data[c]) begin
                    errors++;
                    $display("FAIL rdata ch%0d got %h want %h t=%0t", c, rdata[c], exp_data[c], $time);
                end
                checks++;
                if (err[c] !== exp_err[c]) begin
                    errors++;
                    $display("FAIL addr_err ch%0d got %b want %b t=%0t", c, err[c], exp_err[c], $time);
                end
            end
        end
    end

    // Length of the most recent contiguous stall run per instance.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (stall[c] === 1'b1) run[c]++;
            else if (run[c] != 0) begin
                last_run[c] = run[c];
                run[c] = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", n, got, want);
        end
    endtask

    // One access: request in cycle 0, stall cycles 0..L+1, DONE at L+2.
    // drop_k / rst_k (>=1) abort in that WAIT cycle; scramble wiggles inputs after acceptance.
    task automatic access(input int c, input bit w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int drop_k, input int rst_k, input bit scramble);
        int L;
        int idx;
        bit inr;
        L = lat[c];
        en[c] = 1'b1; we[c] = w; addr[c] = a; sel[c] = s; wd[c] = d;
        exp_stall[c] = 1'b1; exp_err[c] = 1'b0;
        for (int k = 0; k <= L + 1; k++) begin
            if (k > 0) begin
                if (scramble) begin
                    we[c] = 1'($urandom); addr[c] = $urandom;
                    sel[c] = 4'($urandom); wd[c] = $urandom;
                end
                if (k == drop_k) begin
                    en[c] = 1'b0; exp_stall[c] = 1'b0;
                    cyc();
                    return;
                end
                if (k == rst_k) begin
                    rst[c] = 1'b1; exp_stall[c] = 1'b0;
                    cyc();
                    rst[c] = 1'b0; en[c] = 1'b0; exp_data[c] = 32'd0;
                    return;
                end
            end
            cyc();
        end
        inr = ((a >> (DL + 2)) == 0);
        idx = int'((a >> 2) & 32'd15);
        exp_stall[c] = 1'b0;
        exp_err[c]   = !inr;
        if (w && inr) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mem_m[c][idx][8*i +: 8] = d[8*i +: 8];
        end
        if (!w) exp_data[c] = inr ? mem_m[c][idx] : 32'd0;
        cyc();
        en[c] = 1'b0; exp_err[c] = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            rst[c] = 1'b1; en[c] = 1'b0; we[c] = 1'b0; addr[c] = '0; sel[c] = '0; wd[c] = '0;
            exp_data[c] = '0; exp_stall[c] = 1'b0; exp_err[c] = 1'b0;
        end
        cyc();
        chk_en = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;     // request during reset must not stall
        cyc();
        lit("reset_rdata", rdata[0], 32'd0);
        en[0] = 1'b0; en[1] = 1'b0; rst[0] = 1'b0; rst[1] = 1'b0;
        cyc();

        // Fill the modelled address pool of both instances.
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 16; i++)
                access(c, 1'b1, 32'(i * 4), 4'hF, $urandom, -1, -1, 1'b0);

        // Full-word write then read, LAT=2.
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, -1, -1, 1'b0);
        cyc();
        lit("wr_stall_len", 32'(last_run[0]), 32'd4);
        access(0, 1'b0, 32'h10, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("rd_deadbeef", rdata[0], 32'hDEADBEEF);
        cyc();
        lit("rd_stall_len", 32'(last_run[0]), 32'd4);

        // Byte and half-word writes.
        access(0, 1'b1, 32'h11, 4'b0100, 32'h55555555, -1, -1, 1'b0);
        access(0, 1'b0, 32'h10, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("byte_write", rdata[0], 32'hDE55BEEF);
        access(0, 1'b1, 32'h12, 4'b0011, 32'h12341234, -1, -1, 1'b0);
        access(0, 1'b0, 32'h10, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("half_write", rdata[0], 32'hDE551234);

        // Flushed write leaves RAM untouched.
        access(0, 1'b1, 32'h20, 4'hF, 32'h01234567, -1, -1, 1'b0);
        access(0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 2, -1, 1'b1);
        access(0, 1'b0, 32'h20, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("flush_no_write", rdata[0], 32'h01234567);

        // Out-of-range read and write; index would alias word 0.
        access(0, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, -1, -1, 1'b0);
        access(0, 1'b0, 32'h0001_0000, 4'hF, 32'h0, -1, -1, 1'b0);
        lit("oor_rdata", rdata[0], 32'd0);
        access(0, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFFFFFF, -1, -1, 1'b0);
        access(0, 1'b0, 32'h0, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("oor_no_alias", rdata[0], 32'hA5A5A5A5);

        // Reset in the middle of a write.
        access(0, 1'b1, 32'h30, 4'hF, 32'h22222222, -1, -1, 1'b0);
        access(0, 1'b1, 32'h30, 4'hF, 32'h11111111, -1, 2, 1'b0);
        lit("rst_rdata", rdata[0], 32'd0);
        access(0, 1'b0, 32'h30, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("rst_no_write", rdata[0], 32'h22222222);

        // LAT=0 back-to-back reads.
        access(1, 1'b1, 32'h10, 4'hF, 32'hAAAA0001, -1, -1, 1'b0);
        access(1, 1'b1, 32'h14, 4'hF, 32'hBBBB0002, -1, -1, 1'b0);
        access(1, 1'b0, 32'h10, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("lat0_rd_a", rdata[1], 32'hAAAA0001);
        lit("lat0_stall_len_a", 32'(last_run[1]), 32'd2);
        access(1, 1'b0, 32'h14, 4'h0, 32'h0, -1, -1, 1'b0);
        lit("lat0_rd_b", rdata[1], 32'hBBBB0002);
        cyc();
        lit("lat0_stall_len_b", 32'(last_run[1]), 32'd2);

        // Randomized traffic on both instances.
        for (int n = 0; n < 300; n++) begin
            int c, r, dk, rk;
            logic [31:0] a;
            c = $urandom_range(0, 1);
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(14, 31));
            r = $urandom_range(0, 9);
            dk = (r == 0) ? $urandom_range(1, lat[c] + 1) : -1;
            rk = (r == 1) ? $urandom_range(1, lat[c] + 1) : -1;
            access(c, 1'($urandom), a, 4'($urandom), $urandom, dk, rk, 1'($urandom));
            repeat ($urandom_range(0, 2)) cyc();
        end

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
